// File: rtl/clb_config_loader.sv
// CLB config loader: takes words over valid/ready, shifts them LSB-first into the CLB chain.
// Optional CRC-8 of the shifted stream on output crc when CLB_CFG_CRC_EN is defined.
module clb_config_loader #(
  parameter int NUM_CLBS     = 4,
  parameter int BITS_PER_CLB = 17,
  parameter int WORD_W       = 8,
  localparam int CHAIN_LEN   = NUM_CLBS * BITS_PER_CLB,
  localparam int BLW         = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prog_in,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic [BLW-1:0]    bits_left
`ifdef CLB_CFG_CRC_EN
  ,
  output logic [7:0]        crc
`endif
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WLW    = $clog2(NWORDS + 1);
  localparam int IW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int LAST_B = (CHAIN_LEN % WORD_W == 0) ? WORD_W
                                                    : CHAIN_LEN % WORD_W;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state_q, state_d;
  logic [BLW-1:0]    bits_left_q, bits_left_d;
  logic [WLW-1:0]    words_left_q, words_left_d;
  logic [WORD_W-1:0] buf_q, buf_d, shifted;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     last_q, last_d;
  logic              prog_in_q, prog_in_d;
  logic              prog_en_q, prog_en_d;
  logic              done_q, done_d;
  logic              cfg_ready_q, cfg_ready_d;

  // buf_q bit 0 is always the bit currently on prog_in
  assign shifted = buf_q >> 1;

  always_comb begin
    state_d      = state_q;
    bits_left_d  = bits_left_q;
    words_left_d = words_left_q;
    buf_d        = buf_q;
    idx_d        = idx_q;
    last_d       = last_q;
    prog_in_d    = prog_in_q;
    prog_en_d    = 1'b0;
    done_d       = done_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOAD;
          done_d       = 1'b0;
          bits_left_d  = BLW'(CHAIN_LEN);
          words_left_d = WLW'(NWORDS);
        end
      end
      LOAD: begin
        if (prog_en_q)
          bits_left_d = bits_left_q - BLW'(1);
        if (prog_en_q && bits_left_q == BLW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (prog_en_q && idx_q != last_q) begin
          buf_d     = shifted;
          prog_in_d = shifted[0];
          prog_en_d = 1'b1;
          idx_d     = idx_q + IW'(1);
        end else if (cfg_valid && cfg_ready_q) begin
          buf_d        = cfg_data;
          prog_in_d    = cfg_data[0];
          prog_en_d    = 1'b1;
          idx_d        = '0;
          last_d       = (words_left_q == WLW'(1)) ? IW'(LAST_B - 1)
                                                   : IW'(WORD_W - 1);
          words_left_d = words_left_q - WLW'(1);
        end
      end
    endcase
    // ready when empty, or presenting the last used bit (zero-bubble refill)
    cfg_ready_d = (state_d == LOAD) && (words_left_d != '0)
               && (!prog_en_d || idx_d == last_d);
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q      <= IDLE;
      bits_left_q  <= '0;
      words_left_q <= '0;
      buf_q        <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      prog_in_q    <= 1'b0;
      prog_en_q    <= 1'b0;
      done_q       <= 1'b0;
      cfg_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bits_left_q  <= bits_left_d;
      words_left_q <= words_left_d;
      buf_q        <= buf_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      prog_in_q    <= prog_in_d;
      prog_en_q    <= prog_en_d;
      done_q       <= done_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

`ifdef CLB_CFG_CRC_EN
  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (state_q == IDLE && start)
      crc_d = '0;
    else if (prog_en_q)
      crc_d = {crc_q[6:0], 1'b0}
            ^ ({8{crc_q[7] ^ prog_in_q}} & 8'h07);
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) crc_q <= '0;
    else             crc_q <= crc_d;
  end

  assign crc = crc_q;
`endif

  assign cfg_ready = cfg_ready_q;
  assign prog_in   = prog_in_q;
  assign prog_en   = prog_en_q;
  assign busy      = (state_q == LOAD);
  assign done      = done_q;
  assign bits_left = bits_left_q;

endmodule

// File: tb/tb_clb_config_loader.sv
// Bench for clb_config_loader: one-CLB and four-CLB instances checked
// every cycle against a bit-queue model, plus directed literal checks.
module tb_clb_config_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st[2];
  logic       vl[2];
  logic [7:0] dt[2];
  logic       rdy_o[2], pin_o[2], pen_o[2], busy_o[2], done_o[2];
  logic [4:0] bl0;
  logic [6:0] bl1;
`ifdef CLB_CFG_CRC_EN
  logic [7:0] crc_o[2];
`endif

  clb_config_loader #(.NUM_CLBS(1), .BITS_PER_CLB(17), .WORD_W(8)) u_a (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(st[0]),
    .cfg_data(dt[0]), .cfg_valid(vl[0]), .cfg_ready(rdy_o[0]),
    .prog_in(pin_o[0]), .prog_en(pen_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .bits_left(bl0)
`ifdef CLB_CFG_CRC_EN
    , .crc(crc_o[0])
`endif
  );

  clb_config_loader #(.NUM_CLBS(4), .BITS_PER_CLB(17), .WORD_W(8)) u_b (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(st[1]),
    .cfg_data(dt[1]), .cfg_valid(vl[1]), .cfg_ready(rdy_o[1]),
    .prog_in(pin_o[1]), .prog_en(pen_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .bits_left(bl1)
`ifdef CLB_CFG_CRC_EN
    , .crc(crc_o[1])
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [67:0] act,
                         input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int blv(input int d);
    return (d == 0) ? int'(bl0) : int'(bl1);
  endfunction

  // model of each loader: pending bits of the current word kept as a count
  function automatic int chain_len(input int d);
    return (d == 0) ? 17 : 68;
  endfunction
  function automatic int n_words(input int d);
    return (d == 0) ? 3 : 9;
  endfunction
  function automatic int last_bits(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  bit       m_busy[2], m_done[2], m_en[2], m_in[2], m_rdy[2];
  int       m_left[2], m_wleft[2], m_pend[2];
  bit [7:0] m_word[2];
`ifdef CLB_CFG_CRC_EN
  bit [7:0] m_crc[2];
  function automatic bit [7:0] crc_step(input bit [7:0] c, input bit b);
    bit [7:0] n;
    n = {c[6:0], 1'b0};
    if (c[7] ^ b) n = n ^ 8'h07;
    return n;
  endfunction
`endif

  task automatic model_reset(input int d);
    m_busy[d] = 0; m_done[d] = 0; m_en[d] = 0; m_in[d] = 0; m_rdy[d] = 0;
    m_left[d] = 0; m_wleft[d] = 0; m_pend[d] = 0; m_word[d] = '0;
`ifdef CLB_CFG_CRC_EN
    m_crc[d] = '0;
`endif
  endtask

  task automatic model_step(input int d);
    bit cons;
    cons = m_busy[d] && m_en[d];
    if (!m_busy[d]) begin
      if (st[d]) begin
        m_busy[d] = 1; m_done[d] = 0; m_rdy[d] = 1;
        m_left[d] = chain_len(d); m_wleft[d] = n_words(d);
`ifdef CLB_CFG_CRC_EN
        m_crc[d] = '0;
`endif
      end
      return;
    end
    if (cons) begin
      m_left[d]--;
`ifdef CLB_CFG_CRC_EN
      m_crc[d] = crc_step(m_crc[d], m_in[d]);
`endif
    end
    if (cons && m_left[d] == 0) begin
      m_busy[d] = 0; m_done[d] = 1; m_en[d] = 0; m_rdy[d] = 0; m_pend[d] = 0;
      return;
    end
    if (m_pend[d] > 0) begin
      m_in[d] = m_word[d][0];
      m_word[d] = m_word[d] >> 1;
      m_pend[d]--;
      m_en[d] = 1;
    end else if (vl[d] && m_rdy[d]) begin
      m_in[d] = dt[d][0];
      m_word[d] = dt[d] >> 1;
      m_pend[d] = ((m_wleft[d] == 1) ? last_bits(d) : 8) - 1;
      m_wleft[d]--;
      m_en[d] = 1;
    end else begin
      m_en[d] = 0;
    end
    m_rdy[d] = (m_wleft[d] > 0) && (m_pend[d] == 0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      chk("cfg_ready", d, int'(rdy_o[d]), int'(m_rdy[d]));
      chk("prog_en", d, int'(pen_o[d]), int'(m_en[d]));
      chk("prog_in", d, int'(pin_o[d]), int'(m_in[d]));
      chk("busy", d, int'(busy_o[d]), int'(m_busy[d]));
      chk("done", d, int'(done_o[d]), int'(m_done[d]));
      chk("bits_left", d, blv(d), m_left[d]);
`ifdef CLB_CFG_CRC_EN
      chk("crc", d, int'(crc_o[d]), int'(m_crc[d]));
`endif
      if (rst_n) model_step(d);
    end
  end

  // stand-in for the CLB shift chains: last N bits shifted
  logic [16:0] chain_a;
  logic [67:0] chain_b;
  always @(posedge clk) begin
    if (pen_o[0]) chain_a <= {pin_o[0], chain_a[16:1]};
    if (pen_o[1]) chain_b <= {pin_o[1], chain_b[67:1]};
  end

  logic [7:0] wbuf[9];

  function automatic bit pk(input int e, input int p1, input int p2);
    return (e == p1) || (e == p2);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int d, input int nw, input int gap_after,
                          input int gap_len, input int p1, input int p2,
                          output int edges);
    bit xf;
    int t;
    st[d] = 1; step(); st[d] = 0; edges = 1;
    for (int k = 0; k < nw; k++) begin
      vl[d] = 1; dt[d] = wbuf[k]; t = 0;
      do begin
        xf = rdy_o[d];
        st[d] = pk(edges, p1, p2);
        step(); edges++; t++;
      end while (!xf && t < 200);
      vl[d] = 0; st[d] = 0;
      chk("word_accepted", d, int'(xf), 1);
      if (k == gap_after) begin
        t = 0;
        while (pen_o[d] && t < 50) begin step(); edges++; t++; end
        for (int g = 0; g < gap_len; g++) begin
          chk("gap_bits_left", d, blv(d), 9);
          chk("gap_prog_en", d, int'(pen_o[d]), 0);
          step(); edges++;
        end
      end
    end
    t = 0;
    while (!done_o[d] && t < 200) begin
      st[d] = pk(edges, p1, p2);
      step(); edges++; t++;
    end
    st[d] = 0;
    chk("load_done", d, int'(done_o[d]), 1);
    chk("load_not_busy", d, int'(busy_o[d]), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    logic [67:0] exp_b;
    for (int d = 0; d < 2; d++) begin st[d] = 0; vl[d] = 0; dt[d] = '0; end
    repeat (3) step();
    chk("reset_busy", 0, int'(busy_o[0]), 0);
    chk("reset_bits_left", 0, blv(0), 0);
    chk("reset_ready", 0, int'(rdy_o[0]), 0);
    chk("reset_done", 1, int'(done_o[1]), 0);
    rst_n = 1;
    step();

    // reset in the middle of a load
    st[0] = 1; step(); st[0] = 0;
    vl[0] = 1; dt[0] = 8'hA5; step(); vl[0] = 0;
    e = 0;
    while (blv(0) != 12 && e < 50) begin step(); e++; end
    chk("midload_bits_left", 0, blv(0), 12);
    chk("midload_prog_en", 0, int'(pen_o[0]), 1);
    rst_n = 0;
    #1;
    chk("rst_prog_en", 0, int'(pen_o[0]), 0);
    chk("rst_busy", 0, int'(busy_o[0]), 0);
    chk("rst_ready", 0, int'(rdy_o[0]), 0);
    chk("rst_done", 0, int'(done_o[0]), 0);
    step(); rst_n = 1; step();

    // streaming with no gaps
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wbuf[2] = 8'h01;
    run_load(0, 3, -1, 0, -1, -1, e);
    chk("stream_edges", 0, e, 19);
    chk_vec("stream_chain", {51'b0, chain_a}, 68'h13CA5);

    // stall between first and second word
    run_load(0, 3, 0, 4, -1, -1, e);
    chk_vec("stall_chain", {51'b0, chain_a}, 68'h13CA5);

    // truncated last word, then an unaccepted extra word
    wbuf[2] = 8'hFF;
    run_load(0, 3, -1, 0, -1, -1, e);
    chk("trunc_edges", 0, e, 19);
    chk_vec("trunc_chain", {51'b0, chain_a}, 68'h13CA5);
    vl[0] = 1; dt[0] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      chk("extra_ready", 0, int'(rdy_o[0]), 0);
      step();
    end
    vl[0] = 0;
    chk("extra_bits_left", 0, blv(0), 0);

    // start pulses while busy and on the completion edge
    wbuf[2] = 8'h01;
    run_load(0, 3, -1, 0, 5, 18, e);
    chk("ignored_edges", 0, e, 19);
    step();
    chk("after_completion_busy", 0, int'(busy_o[0]), 0);
    chk("after_completion_done", 0, int'(done_o[0]), 1);
    chk_vec("ignored_chain", {51'b0, chain_a}, 68'h13CA5);

    // four-CLB chain, nine words
    for (int k = 0; k < 9; k++) wbuf[k] = 8'($urandom);
    run_load(1, 9, -1, 0, -1, -1, e);
    chk("b_edges", 1, e, 70);
    for (int i = 0; i < 68; i++) exp_b[i] = wbuf[i / 8][i % 8];
    chk_vec("b_chain", chain_b, exp_b);

    // random traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        st[d] = ($urandom_range(0, 15) == 0);
        vl[d] = 1'($urandom_range(0, 1));
        dt[d] = 8'($urandom);
      end
      if (i == 1500) rst_n = 0;
      if (i == 1502) rst_n = 1;
      step();
    end
    for (int d = 0; d < 2; d++) begin st[d] = 0; vl[d] = 0; end
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
